// File: rtl/coeff_accumulator.sv
// Serial accumulator for CGES sign-extended coefficients: snapshots the array on start,
// adds one term per clock with a single MAX-bit adder and hands back sum + non-zero count.
module coeff_accumulator #(
    parameter int BITS = 32,
    parameter int CGES = 49,
    parameter int MAX  = $clog2(CGES) + BITS,
    parameter int CNTW = $clog2(CGES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [MAX-1:0]  coeff [CGES-1:0],
    output logic            busy,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [MAX-1:0]  sum,
    output logic [CNTW-1:0] nz_count
);

    // MAX must hold CGES terms of BITS bits without wrapping.
    if (MAX < BITS + $clog2(CGES)) begin : g_width_check
        $error("coeff_accumulator: MAX too narrow for CGES terms of BITS bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [MAX-1:0]  snapshot [CGES-1:0];
    logic signed [MAX-1:0]  acc;
    logic signed [MAX-1:0]  term;
    logic signed [MAX-1:0]  acc_sum;
    logic        [CNTW-1:0] index;
    logic        [CNTW-1:0] nz;
    logic        [CNTW-1:0] nz_sum;
    logic                   last_term;

    // Two's-complement add, modulo 2^MAX: the result width drops the carry.
    function automatic logic signed [MAX-1:0] add_wrap(
        input logic signed [MAX-1:0] a,
        input logic signed [MAX-1:0] b
    );
        return a + b;
    endfunction

    // Term select as a compare mux so the index never needs to match the array's address width.
    always_comb begin
        term = '0;
        for (int i = 0; i < CGES; i++) begin
            if (index == CNTW'(i)) begin
                term = snapshot[i];
            end
        end
    end

    assign acc_sum   = add_wrap(acc, term);
    assign nz_sum    = nz + CNTW'(term != '0);
    assign last_term = (index == CNTW'(CGES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = ACCUM;
            ACCUM:   if (last_term)    state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Datapath: snapshot on acceptance, one term per ACCUM cycle, publish on the last term.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            nz       <= '0;
            index    <= '0;
            sum      <= '0;
            nz_count <= '0;
            for (int i = 0; i < CGES; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < CGES; i++) begin
                            snapshot[i] <= $signed(coeff[i]);
                        end
                        acc   <= '0;
                        nz    <= '0;
                        index <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    nz  <= nz_sum;
                    if (last_term) begin
                        sum      <= acc_sum;
                        nz_count <= nz_sum;
                        index    <= '0;
                    end else begin
                        index <= index + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_coeff_accumulator.sv
// Randomised self-checking bench for coeff_accumulator (BITS=8, CGES=4, MAX=10, CNTW=3)
// against a plain-arithmetic reference model.
module tb_coeff_accumulator;

    localparam int BITS = 8;
    localparam int CGES = 4;
    localparam int MAX  = 10;
    localparam int CNTW = 3;

    typedef int vec_t [CGES];

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [MAX-1:0]  coeff [CGES-1:0];
    logic            busy;
    logic            result_valid;
    logic            result_ready;
    logic [MAX-1:0]  sum;
    logic [CNTW-1:0] nz_count;

    int n_chk  = 0;
    int n_fail = 0;

    coeff_accumulator #(.BITS(BITS), .CGES(CGES)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .coeff        (coeff),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .nz_count     (nz_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: integer sum of the signed terms, reduced modulo 2^MAX.
    function automatic logic [31:0] ref_sum(input vec_t v);
        int s = 0;
        for (int i = 0; i < CGES; i++) s += v[i];
        return 32'(s) & ((32'd1 << MAX) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_nz(input vec_t v);
        int n = 0;
        for (int i = 0; i < CGES; i++) if (v[i] != 0) n++;
        return 32'(n);
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < CGES; i++) begin
            if ($urandom_range(0, 3) == 0) v[i] = 0;
            else                           v[i] = int'($urandom_range(0, 255)) - 128;
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        for (int i = 0; i < CGES; i++) coeff[i] = MAX'(v[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to a bound for result_valid; returns the number of edges taken.
    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One complete operation with result_ready=1; coeff is replaced by `after` right after acceptance.
    task automatic run_op(input string tag, input vec_t v, input vec_t after,
                          input logic [31:0] exp_sum, input logic [31:0] exp_nz);
        int n;
        drive(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(after);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'(CGES));
        chk({tag, "_sum"}, 32'(sum), exp_sum);
        chk({tag, "_nz"}, 32'(nz_count), exp_nz);
        tick();
        chk({tag, "_vld_clr"}, 32'(result_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v, w;
        int   n;
        logic [31:0] hs, hn;

        reset        = 1'b1;
        start        = 1'b0;
        result_ready = 1'b1;
        for (int i = 0; i < CGES; i++) coeff[i] = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(result_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_nz", 32'(nz_count), 32'd0);
        reset = 1'b0;
        tick();

        // Mixed signs
        v = '{5, -3, 100, -128};
        run_op("mixed", v, rand_vec(), 32'h3E6, 32'd4);

        // Extremes
        v = '{127, 127, 127, 127};
        run_op("max", v, rand_vec(), 32'h1FC, 32'd4);
        v = '{-128, -128, -128, -128};
        run_op("min", v, rand_vec(), 32'h200, 32'd4);

        // Zeros, with coeff changed after acceptance
        v = '{0, 7, 0, 0};
        w = '{1, 1, 1, 1};
        run_op("snap", v, w, 32'd7, 32'd1);

        // Backpressure with start pulsed during DONE
        v = rand_vec();
        hs = ref_sum(v);
        hn = ref_nz(v);
        result_ready = 1'b0;
        drive(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(rand_vec());
        wait_valid(n);
        chk("bp_lat", 32'(n), 32'(CGES));
        for (int c = 0; c < 6; c++) begin
            start = 1'b1;
            drive(rand_vec());
            tick();
            chk($sformatf("bp_vld%0d", c), 32'(result_valid), 32'd1);
            chk($sformatf("bp_sum%0d", c), 32'(sum), hs);
            chk($sformatf("bp_nz%0d", c), 32'(nz_count), hn);
        end
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_hs_vld", 32'(result_valid), 32'd0);
        chk("bp_hs_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("bp_quiet%0d", c), 32'({busy, result_valid}), 32'd0);
        end

        // Reset on the second ACCUM cycle
        drive(rand_vec());
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_vld", 32'(result_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_nz", 32'(nz_count), 32'd0);
        v = '{1, 2, 3, 4};
        run_op("post_rst", v, rand_vec(), 32'd10, 32'd4);

        // Random single operations
        for (int k = 0; k < 8; k++) begin
            v = rand_vec();
            run_op($sformatf("rnd%0d", k), v, rand_vec(), ref_sum(v), ref_nz(v));
        end

        // Back-to-back with start held high: one acceptance every CGES+2 cycles
        start = 1'b1;
        for (int op = 0; op < 5; op++) begin
            v = rand_vec();
            hs = ref_sum(v);
            hn = ref_nz(v);
            drive(v);
            tick();
            chk($sformatf("b2b%0d_acc", op), 32'(busy), 32'd1);
            for (int c = 1; c <= CGES + 1; c++) begin
                drive(rand_vec());
                tick();
                if (c == CGES) begin
                    chk($sformatf("b2b%0d_vld", op), 32'(result_valid), 32'd1);
                    chk($sformatf("b2b%0d_sum", op), 32'(sum), hs);
                    chk($sformatf("b2b%0d_nz", op), 32'(nz_count), hn);
                end else if (c == CGES + 1) begin
                    chk($sformatf("b2b%0d_idle", op), 32'({busy, result_valid}), 32'd0);
                end else begin
                    chk($sformatf("b2b%0d_early%0d", op, c), 32'(result_valid), 32'd0);
                end
            end
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coeff_accumulator.md
Name: coeff_accumulator

Overview:
- Downstream consumer of the coefficient pre-step stage.
- Takes the CGES sign-extended, mask-gated coefficients (MAX bits each), snapshots them on a start request, and sums them serially, one term per clock.
- Presents a MAX-bit two's-complement sum and a count of non-zero terms through a valid/ready result handshake.
- The serial datapath uses a single MAX-bit adder instead of a CGES-input adder tree.

Parameters:
- BITS, 32: raw coefficient width before sign extension.
- CGES, 49: number of coefficient terms.
- MAX, $clog2(CGES)+BITS: width of each input term and of the sum (carries the headroom for CGES terms).
- CNTW, $clog2(CGES+1): width of the index and non-zero counters.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to sum the current coeff array.
- coeff  input  [MAX-1:0] x CGES (unpacked [CGES-1:0])  sign-extended terms from the pre-step stage.
- busy  output  1  high whenever state is not IDLE.
- result_valid  output  1  sum/nz_count are valid.
- result_ready  input  1  downstream accepts the result.
- sum  output  [MAX-1:0]  two's-complement sum of all snapshot terms.
- nz_count  output  [CNTW-1:0]  number of snapshot terms not equal to zero.

Behaviour:
- One clock (clk). Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: state=IDLE, busy=0, result_valid=0, sum=0, nz_count=0, index=0, snapshot=all zero.
- Reset has priority over every other input in every state.
- States and transitions:
  - IDLE: start=1 -> capture all CGES coeff words into the snapshot; clear accumulator, nz counter and index; go to ACCUM. start=0 -> stay.
  - ACCUM: each cycle, acc += snapshot[index]; nz += (snapshot[index]!=0); index++. After index CGES-1 is added, go to DONE.
  - DONE: result_valid=1; sum and nz_count hold stable. result_ready=1 -> result_valid=0, go to IDLE on that edge.
- Latency: start is accepted at edge k; terms are added at edges k+1 .. k+CGES; result_valid rises after edge k+CGES. Total is CGES cycles from acceptance to valid.
- Back-to-back: start can be accepted at the earliest one cycle after the handshake edge (in IDLE).
- start is ignored while busy=1, including in DONE with result_ready=1 in the same cycle. A new request is only accepted from IDLE.
- Snapshot isolation: changes on coeff after the acceptance edge must not affect the result.
- Arithmetic: signed addition, modulo 2^MAX (wrap, no saturation, no overflow flag). With inputs that are sign-extended BITS-bit values, no wrap can occur.
- sum/nz_count are updated only when entering DONE, and hold their previous result while in IDLE/ACCUM.
- Index wrap: index never exceeds CGES-1 while addressing the snapshot. It is cleared on start acceptance.
- Reset mid-ACCUM or in DONE: the operation is abandoned, no result_valid pulse, outputs return to reset values.
- CGES=1 is legal: one ACCUM cycle, then DONE.

Test Plan:
(all with BITS=8, CGES=4, MAX=10, CNTW=3)
1. Mixed signs: coeff={5,-3,100,-128}, pulse start, hold result_ready=1 -> result_valid exactly 4 cycles after acceptance, sum=10'h3E6 (-26), nz_count=4, busy low the cycle after the handshake.
2. Extremes: all coeff=127 -> sum=508 (10'h1FC). All coeff=-128 -> sum=10'h200 (-512). No wrap, nz_count=4 in both cases.
3. Zeros and snapshot: coeff={0,7,0,0}, start, then set coeff={1,1,1,1} the next cycle -> sum=7, nz_count=1.
4. Backpressure: result_ready=0 for 6 cycles after valid, start pulsed during DONE -> valid, sum and nz_count stable throughout; start ignored; on ready=1 return to IDLE; no second result without a fresh start.
5. Reset mid-operation: assert reset on the 2nd ACCUM cycle -> next cycle busy=0, result_valid=0, sum=0, nz_count=0; a subsequent start with {1,2,3,4} gives sum=10 normally.
6. Back-to-back: start held high continuously with result_ready=1 -> a new acceptance one cycle after each handshake, period CGES+2 cycles, each sum correct for the coeff present at its acceptance edge.
